// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO in front of the frame FSM.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 bit_end, last_stop, can_load, load;
  logic                 src_valid, src_pe, src_po, src_s2;
  logic [DATA_BITS-1:0] src_data;
  logic                 fifo_nonempty;

  assign bit_end   = (cnt_q == '0);
  // Final cycle of the final stop bit: the slot where a new frame may be loaded gaplessly.
  assign last_stop = (state_q == STOP) && bit_end && (!stop2_q || bit_idx_q == 4'd1);
  assign can_load  = (state_q == IDLE) || last_stop;
  assign load      = can_load && src_valid;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_BITS + 3;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               fifo_full, push, pop;
  logic [ENTRY_W-1:0] head;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign fifo_full     = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign push          = tx_valid && !fifo_full;
  assign pop           = load;
  assign head          = fifo_mem[rd_ptr_q];
  assign {src_s2, src_po, src_pe, src_data} = head;
  assign src_valid     = fifo_nonempty;
  assign tx_ready      = !fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {stop2, parity_odd, parity_en, tx_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  assign src_valid     = tx_valid;
  assign src_data      = tx_data;
  assign src_pe        = parity_en;
  assign src_po        = parity_odd;
  assign src_s2        = stop2;
  assign fifo_nonempty = 1'b0;
  assign tx_ready      = can_load;
`endif

  // txd_d always carries the level of the bit being entered, so txd is a plain flop output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != IDLE) cnt_d = bit_end ? CNT_RELOAD : cnt_q - 1'b1;

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          txd_d     = 1'b1;
          bit_idx_d = '0;
        end
      end
      STOP: begin
        if (last_stop) begin
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (bit_end) begin
          bit_idx_d = 4'd1;
        end
      end
      default: ;
    endcase

    if (load) begin
      state_d   = START;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
      cnt_d     = CNT_RELOAD;
      bit_idx_d = '0;
      shift_d   = src_data;
      par_en_d  = src_pe;
      par_bit_d = (^src_data) ^ src_po;
      stop2_d   = src_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign txd     = txd_q;
  assign tx_done = done_q;
  assign busy    = busy_q | fifo_nonempty;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It adds:
- an internal baud divider
- configurable data width
- runtime parity and stop-bit selection
- a valid/ready byte interface with gapless back-to-back frames
- an optional input FIFO

It sits between the host-controller command/debug logic and the serial TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2; used only with UART_TX_FIFO_EN

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  block accepts tx_data this cycle
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even
stop2  input  1  1 = two stop bits, 0 = one
txd  output  1  serial line, idle high
busy  output  1  frame in progress (or FIFO non-empty)
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async): txd=1, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, FIFO empty. tx_ready=1 once reset deasserts.
- Reset mid-frame: txd returns high immediately; the frame is abandoned with no tx_done. The next handshake sends a full frame.
- Handshake: tx_valid && tx_ready on a rising edge.
  - Latches tx_data, parity_en, parity_odd and stop2 for the whole frame.
  - Later changes on these inputs do not affect the frame in flight.
- Frame format, LSB first:
  - start bit (0)
  - DATA_BITS data bits
  - optional parity bit
  - 1 or 2 stop bits (1)
- Every bit is held exactly CLKS_PER_BIT cycles. Frame length = (1 + DATA_BITS + parity_en + 1 + stop2) * CLKS_PER_BIT.
- Parity: even = XOR of the data bits; odd = its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY or STOP after the last data bit.
  - PARITY -> STOP.
  - STOP -> IDLE, or -> START if a new handshake occurs in the final stop cycle.
- Baud counter reloads to CLKS_PER_BIT-1 at each bit start and counts down. The bit advances when the counter reaches 0.
- Latency: handshake in cycle N -> txd=0 from cycle N+1. txd is registered and glitch-free.
- Without FIFO, tx_ready (combinational from state/counter) = IDLE, or last cycle of the last stop bit. This makes back-to-back frames gapless.
- busy=1 from N+1 until the last stop bit completes.
- tx_done=1 for the single cycle after the last stop bit completes; it coincides with the STOP exit.
- tx_valid with tx_ready=0 is ignored; nothing is lost or latched.

Optional Feature:
Macro: UART_TX_FIFO_EN.
- Defined:
  - tx_ready = FIFO not full. Push when full is blocked even if a pop occurs that cycle.
  - The FSM pops when in IDLE or in the final stop cycle with FIFO non-empty. Push into an empty FIFO while idle -> start bit 2 cycles later.
  - busy = frame in progress OR FIFO non-empty.
  - parity_en, parity_odd and stop2 are stored per entry with the data.
  - Order is strictly FIFO.
- Undefined: no FIFO storage; behaviour exactly as in Behaviour.

Test Plan:
All scenarios use DATA_BITS=8, CLKS_PER_BIT=4.
1. Send 0xA5, parity_en=0, stop2=0 -> txd = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles. Frame is 40 cycles; tx_done pulses once at cycle 40; busy high for 40 cycles.
2. Send 0x07 with parity_en=1, parity_odd=0, stop2=1 -> parity bit = 1 and frame = 48 cycles. Repeat with parity_odd=1 -> parity bit = 0.
3. tx_valid held with 0x00 then 0xFF (no FIFO) -> stop bit of frame 1 directly followed by start of frame 2, no extra idle cycle. tx_ready high only in IDLE and the final stop cycle.
4. Assert reset during data bit 3 of 0x55 -> txd=1 and busy=0 immediately, no tx_done. Then send 0x3C -> complete correct frame.
5. Change tx_data and parity_odd mid-frame while tx_ready=0 -> the current frame is unaffected. The new values are sent only after the next handshake.
6. With UART_TX_FIFO_EN and FIFO_DEPTH=4, push 6 bytes back-to-back from idle:
   - byte 1 is popped immediately; 4 are buffered; the sixth stalls with tx_ready=0 until frame 1 ends.
   - all 6 bytes are emitted in order with no gaps; busy stays high throughout.
